// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state
// encoding, default base address, data/strobe widths and a lane-merge helper.
package dmem_pkg;

  localparam int          DMEM_DATA_W            = 32;
  localparam int          DMEM_STRB_W            = DMEM_DATA_W / 8;
  localparam logic [31:0] DMEM_BASE_ADDR_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Byte-lane merge: lanes with a set strobe bit take the new data.
  function automatic logic [DMEM_DATA_W-1:0] merge_lanes(
    input logic [DMEM_DATA_W-1:0] old_word,
    input logic [DMEM_DATA_W-1:0] new_word,
    input logic [DMEM_STRB_W-1:0] strb
  );
    logic [DMEM_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < DMEM_STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// Wait-state down-counter: loads a start value, decrements on request until
// zero and reports when it sits at zero.
module dmem_wait_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/data_mem_resp.sv
// Word-organised data memory behind a valid/ready request/response handshake
// with configurable wait states. Define DMEM_MISALIGN_CHECK_EN to fault
// accesses whose address is not word aligned.
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR_DEFAULT,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [DMEM_DATA_W-1:0] req_wdata,
  input  logic [DMEM_STRB_W-1:0] req_wstrb,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DMEM_DATA_W-1:0] resp_rdata,
  output logic                   resp_err
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

  dmem_state_t state, state_nxt;

  logic accept;
  logic do_acc;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  // Request capture stage (data only, no reset)
  logic                   we_p0;
  logic [31:0]            addr_p0;
  logic [DMEM_DATA_W-1:0] wdata_p0;
  logic [DMEM_STRB_W-1:0] wstrb_p0;

  logic                   acc_we;
  logic [31:0]            acc_addr;
  logic [31:0]            acc_off;
  logic [DMEM_DATA_W-1:0] acc_wdata;
  logic [DMEM_STRB_W-1:0] acc_strb;
  logic [IDX_W-1:0]       acc_idx;
  logic                   acc_err;

  logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

  dmem_wait_cnt #(
    .CNT_W (4)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    do_acc    = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      WAIT: begin
        if (cnt_zero) begin
          do_acc    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        req_ready = resp_ready;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // An accept overrides the fall back to IDLE, giving back-to-back transfers
    accept = req_valid && req_ready;
    if (accept) begin
      cnt_load  = 1'b1;
      state_nxt = NO_WAIT ? RESP : WAIT;
      if (NO_WAIT) do_acc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      wstrb_p0 <= req_wstrb;
    end
  end

  // Access stage: with no wait states the access uses the live request
  assign acc_we    = NO_WAIT ? req_we    : we_p0;
  assign acc_addr  = NO_WAIT ? req_addr  : addr_p0;
  assign acc_wdata = NO_WAIT ? req_wdata : wdata_p0;
  assign acc_strb  = NO_WAIT ? req_wstrb : wstrb_p0;

  // Below-base addresses wrap to a large offset and fail the span check
  assign acc_off = acc_addr - BASE_ADDR;
  assign acc_idx = acc_off[IDX_W+1:2];

  always_comb begin
    acc_err = ({1'b0, acc_off} >= SPAN);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (acc_addr[1:0] != 2'b00) acc_err = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst && do_acc && acc_we && !acc_err) begin
      mem[acc_idx] <= merge_lanes(mem[acc_idx], acc_wdata, acc_strb);
    end
  end

  // Response stage: held until the CPU takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (do_acc) begin
      resp_err   <= acc_err;
      resp_rdata <= (acc_we || acc_err) ? '0 : mem[acc_idx];
    end
  end

  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp (default parameters): table-driven
// accesses with a scoreboard, plus hand-written stall, back-to-back and
// reset-during-wait sequences.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  data_mem_resp dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vt.push_back(v);
  endfunction

  // Present a request, wait (bounded) for the accept edge, record expectation
  task automatic send(input vec_t v);
    bit   got;
    exp_t e;
    got       = 1'b0;
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wstrb = v.strb;
    for (int t = 0; t < 40; t++) begin
      if (req_ready) begin
        @(posedge clk);
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    #1;
    acc_cyc   = cyc;
    e.rdata   = v.exp_rdata;
    e.err     = v.exp_err;
    sb.push_back(e);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    chk("accept_timeout", 32'(got), 32'd1);
  endtask

  // Wait (bounded) for the response, check latency and data, optionally take it
  task automatic recv(input string name, input bit complete);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_resp_timeout"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(cyc - acc_cyc), 32'd3);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({name, "_rdata"}, resp_rdata, e.rdata);
      chk({name, "_err"}, 32'(resp_err), 32'(e.err));
    end else begin
      chk({name, "_scoreboard_empty"}, 32'd0, 32'd1);
    end
    if (complete) begin
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk({name, "_resp_drop"}, 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    add(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
    add(0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0);
    add(1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0, 0);
    add(1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 0);
    add(0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 0);
    add(1, 32'h8000_0004, 32'h0BAD_C0DE, 4'hF, 32'h0, 0);
    add(1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 0);
    add(1, 32'h8000_0FFC, 32'h1234_5678, 4'hF, 32'h0, 0);
    add(0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0, 1);
    add(0, 32'h8000_1000, 32'h0,         4'h0, 32'h0, 1);
    add(1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
    add(1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
    add(0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h1234_5678, 0);
    add(0, 32'h8000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 0);
    add(1, 32'h8000_0010, 32'h0,         4'h0, 32'h0, 0);
    add(0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
    add(0, 32'h8000_0002, 32'h0,         4'h0, 32'h0, 1);
`else
    add(0, 32'h8000_0002, 32'h0,         4'h0, 32'hCAFE_F00D, 0);
`endif

    for (int i = 0; i < vt.size(); i++) begin
      send(vt[i]);
      recv($sformatf("vec%0d", i), 1'b1);
    end

    // Stall in RESP for five cycles, then complete and accept on one edge
    add(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    send(vt[vt.size()-1]);
    recv("hold_first", 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("hold_err", 32'(resp_err), 32'd0);
    end
    chk("hold_req_ready_low", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h8000_0020;
    #1;
    chk("b2b_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    begin
      exp_t e;
      e.rdata = 32'h11BB_33DD;
      e.err   = 1'b0;
      sb.push_back(e);
    end
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    chk("b2b_in_wait", 32'(resp_valid), 32'd0);
    chk("b2b_req_ready_wait", 32'(req_ready), 32'd0);
    recv("b2b_second", 1'b1);

    // Reset one cycle after accepting a store: the store must be dropped
    v.we = 1'b1; v.addr = 32'h8000_0004; v.wdata = 32'h5555_5555; v.strb = 4'hF;
    v.exp_rdata = 32'h0; v.exp_err = 1'b0;
    send(v);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("wait_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("wait_rst_req_ready", 32'(req_ready), 32'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("wait_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("wait_rst_rdata_cleared", resp_rdata, 32'd0);
    v.we = 1'b0; v.addr = 32'h8000_0004; v.wdata = 32'h0; v.strb = 4'h0;
    v.exp_rdata = 32'h0BAD_C0DE; v.exp_err = 1'b0;
    send(v);
    recv("wait_rst_old_data", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of 32-bit storage words, power of two.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15: wait states between request accept and response.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low.
REQ-006 req_valid  in  1  the CPU presents a load or store request.
REQ-007 req_ready  out  1  the block accepts the request this cycle.
REQ-008 req_we  in  1  1 = store (sw_en side), 0 = load (lw_en side).
REQ-009 req_addr  in  32  byte address of the access.
REQ-010 req_wdata  in  32  store data.
REQ-011 req_wstrb  in  4  byte enables for the store; bit i enables byte lane i.
REQ-012 resp_valid  out  1  the response is valid.
REQ-013 resp_ready  in  1  the CPU takes the response.
REQ-014 resp_rdata  out  32  load data; 0 for stores and on error.
REQ-015 resp_err  out  1  the access faulted; valid while resp_valid is 1.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, WAIT and RESP.
REQ-017 IDLE: req_ready=1. When req_valid is also 1, the block SHALL latch addr, we, wdata and wstrb, load the wait counter with WAIT_CYCLES, and move to WAIT (or directly to RESP when WAIT_CYCLES=0).
REQ-018 WAIT: req_ready=0. The counter SHALL decrement once per cycle; when it reaches 0, the access SHALL be performed and the FSM SHALL move to RESP.
REQ-019 Latency: resp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 RESP: resp_valid=1 and resp_rdata/resp_err SHALL stay stable until resp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-021 In RESP, req_ready SHALL equal resp_ready, so a new request can be accepted on the same edge the response completes; the FSM then goes to WAIT (or stays in RESP when WAIT_CYCLES=0).
REQ-022 Word index = (addr - BASE_ADDR) >> 2. An address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) SHALL set resp_err=1 and resp_rdata=0, with no write.
REQ-023 Store: only the lanes with a set wstrb bit SHALL be written; wstrb=0 is a legal no-op with resp_err=0.
REQ-024 Load: resp_rdata SHALL be the full word at the index; the CPU performs lane selection.
REQ-025 A load that follows a store to the same word SHALL return the stored data; no forwarding hazard is permitted.
REQ-026 req_* inputs SHALL be ignored outside the accept cycle.

Reset
REQ-027 Asserting rst SHALL immediately force: FSM=IDLE, counter=0, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-028 Reset SHALL NOT clear the storage array.
REQ-029 Reset during WAIT SHALL drop the pending store; memory is unchanged.

Configuration
REQ-030 Macro DMEM_MISALIGN_CHECK_EN, when defined, SHALL make any access with addr[1:0] != 0 respond with resp_err=1, resp_rdata=0 and no write.
REQ-031 Without DMEM_MISALIGN_CHECK_EN, addr[1:0] SHALL be ignored and the access treated as word-aligned.

Structure
REQ-032 Package dmem_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP), the default BASE_ADDR constant and the strobe-width constant.
REQ-033 The wait-state down-counter SHALL be a separate sub-module, dmem_wait_cnt (load, decrement, zero flag).
REQ-034 The storage array SHALL be a plain register array inside data_mem_resp, with no initial values required.

Verification
REQ-035 Reset with WAIT_CYCLES=2: store 32'hDEADBEEF to 32'h8000_0010 with wstrb=4'hF, then load from the same address -> resp_rdata=32'hDEADBEEF, resp_err=0, resp_valid exactly 3 cycles after each accept.
REQ-036 Memory holds 32'h11223344 at 32'h8000_0020; store 32'hAABBCCDD with wstrb=4'b0101, then load -> 32'h11BB33DD.
REQ-037 Load from 32'h7FFF_FFFC and from 32'h8000_1000 (DEPTH_WORDS=1024) -> resp_err=1 and resp_rdata=0 both times; array unchanged.
REQ-038 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stay stable; then assert resp_ready with req_valid=1 -> back-to-back accept on the same edge.
REQ-039 Assert rst one cycle after accepting a store to 32'h8000_0004 -> resp_valid=0; a later load returns the old contents.
REQ-040 With DMEM_MISALIGN_CHECK_EN, load from 32'h8000_0002 -> resp_err=1; without the macro the same load returns word 32'h8000_0000 with resp_err=0.
